data_enc: RTL
=============

// Module: data_enc
// PURPOSE
// Transmit-side command encoder for the Dynamic-TMR link. Accepts a mode, speed and direction command
// over a valid/ready handshake and packs it into a 10-bit payload. It Hamming(14,10) encodes the payload
// and presents the codeword on a parallel bus with a one-cycle avl strobe.
// It enforces an inter-frame gap and periodically re-sends the last command so the receiver stays refreshed.
// PARAMETERS
// data_l      14    codeword width (fixed; Hamming 14,10)
// cmd_l       4     speed_cmd / dir_cmd width
// GAP_CYC     4     idle cycles forced after every frame before the next one (0 = none)
// REFRESH_CYC 1000  idle cycles without a new command before the last command is re-sent (0 = never)
// PORTS
// clk        in   1       clock
// rst        in   1       reset, asynchronous, active-high
// cmd_valid  in   1       command present
// cmd_ready  out  1       encoder can accept; 1 only in state IDLE
// mode       in   2       operating mode
// speed_cmd  in   cmd_l   speed command
// dir_cmd    in   cmd_l   direction command
// data       out  data_l  encoded codeword, registered, held between frames
// avl        out  1       one-cycle strobe: data is a new or refreshed frame
// tx_cnt     out  8       frames sent since reset, wraps 255->0
// BEHAVIOUR
// - Payload p[9:0] = {dir_cmd, speed_cmd, mode}.
// - Codeword position k (1..14) maps to data[k-1]. Parity bits sit at positions 1, 2, 4 and 8.
//   p[0..9] fill positions 3,5,6,7,9,10,11,12,13,14 in order.
//   Pi (i = 1, 2, 4, 8) = XOR of all positions whose index has bit i set (even parity).
// - Reset: state IDLE, data=0, avl=0, tx_cnt=0, stored payload=0, has_cmd=0, refresh counter=0.
//   cmd_ready=1 in the first cycle after reset release.
// - FSM IDLE:
//   - Accept when cmd_valid & cmd_ready at a clock edge. At that same edge: store p, set has_cmd=1,
//     data<=enc(p), avl<=1, tx_cnt<=tx_cnt+1, clear the refresh counter, go to GAP.
//   - Latency: avl and data are valid in the cycle after acceptance.
// - FSM GAP: avl<=0 after one cycle and cmd_ready=0. Stay GAP_CYC cycles, then return to IDLE.
//   With GAP_CYC=0, return to IDLE the cycle after avl.
// - Refresh:
//   - In IDLE with has_cmd=1 and REFRESH_CYC>0, the counter increments each cycle.
//   - When it reaches REFRESH_CYC, re-send the stored payload exactly like an accept
//     (avl, tx_cnt+1, GAP) and clear the counter.
//   - Never refresh before the first command.
// - Simultaneous new command and refresh expiry: the new command wins, one frame carrying the new
//   payload is sent, and the counter restarts.
// - Inputs are ignored outside IDLE; the sender must hold cmd_valid until cmd_ready.
// - Reset mid-GAP or mid-frame: immediate return to reset values, no partial frame, avl drops asynchronously.
// - avl is never high in two consecutive cycles.
// CONFIGURATION
// - Macro FAULT_INJ_EN adds ports inj_en (in, 1) and inj_pos (in, 4).
//   - If inj_en=1 when a frame is launched and inj_pos<=13, bit data[inj_pos] of that frame is inverted.
//   - inj_pos>=14 injects nothing. The stored payload is never corrupted; later refreshes are clean
//     unless inj_en is still 1.
//   - Used to exercise receiver correction and its err_rate counter.
// - Without FAULT_INJ_EN: the ports are absent and data is always enc(p).
// TESTING
// 1. Reset, then cmd mode=01, speed=0, dir=0 -> next cycle data=14'h0007, avl=1 for 1 cycle, tx_cnt=1.
// 2. Cmd mode=11, speed=F, dir=F -> data=14'h3F74. With GAP_CYC=4, cmd_ready=0 for exactly 5 cycles after accept.
// 3. REFRESH_CYC=20, no new cmd -> identical codeword re-sent with avl, 20 IDLE cycles after the GAP ends.
//    No avl ever appears before the first command.
// 4. cmd_valid asserted in the refresh-expiry cycle -> exactly one frame, carrying the new payload.
// 5. Assert rst during GAP -> avl=0, data=0, tx_cnt=0 at once; cmd_ready=1 after release.
// 6. FAULT_INJ_EN, inj_en=1, inj_pos=2, payload as in test 1 -> data=14'h0003; next refresh with inj_en=0 -> 14'h0007.

Source files
------------

// File: rtl/data_enc_if.sv
// Command/codeword bus between a command source and the data_enc Hamming(14,10) encoder.
interface data_enc_if #(
    parameter int data_l = 14,
    parameter int cmd_l  = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        mode;
    logic [cmd_l-1:0]  speed_cmd;
    logic [cmd_l-1:0]  dir_cmd;
    logic [data_l-1:0] data;
    logic              avl;
    logic [7:0]        tx_cnt;

    modport master (
        output cmd_valid, mode, speed_cmd, dir_cmd,
        input  cmd_ready, data, avl, tx_cnt
    );

    modport slave (
        input  cmd_valid, mode, speed_cmd, dir_cmd,
        output cmd_ready, data, avl, tx_cnt
    );
endinterface

// File: rtl/data_enc.sv
// Transmit-side command encoder: packs mode/speed/dir, Hamming(14,10) encodes, enforces a frame gap
// and periodically refreshes the last command. Optional macro FAULT_INJ_EN adds single-bit error injection.
module data_enc #(
    parameter int data_l      = 14,
    parameter int cmd_l       = 4,
    parameter int GAP_CYC     = 4,
    parameter int REFRESH_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst,
    data_enc_if.slave  bus
`ifdef FAULT_INJ_EN
    ,
    input  logic       inj_en,
    input  logic [3:0] inj_pos
`endif
);

    localparam int PAY_W = 2 + 2 * cmd_l;
    localparam int GW    = $clog2(GAP_CYC + 2);
    localparam int RW    = $clog2(REFRESH_CYC + 2);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYC - 1);
    localparam bit REF_EN = (REFRESH_CYC > 0);

    typedef enum logic {IDLE, GAP} state_t;

    state_t            state;
    logic [PAY_W-1:0]  payload;
    logic              has_cmd;
    logic [RW-1:0]     ref_cnt;
    logic [GW-1:0]     gap_cnt;
    logic [data_l-1:0] data_r;
    logic              avl_r;
    logic [7:0]        tx_cnt_r;

    logic [PAY_W-1:0]  new_p;
    logic              refresh_due;
    logic              launch;
    logic [PAY_W-1:0]  launch_p;
    logic [data_l-1:0] inj_mask;

    // Codeword position k lives in c[k-1]; parity at positions 1,2,4,8, even parity.
    function automatic logic [data_l-1:0] enc(input logic [PAY_W-1:0] p);
        logic [data_l-1:0] c;
        c     = '0;
        c[2]  = p[0];
        c[4]  = p[1];
        c[5]  = p[2];
        c[6]  = p[3];
        c[8]  = p[4];
        c[9]  = p[5];
        c[10] = p[6];
        c[11] = p[7];
        c[12] = p[8];
        c[13] = p[9];
        c[0]  = c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10] ^ c[12];
        c[1]  = c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10] ^ c[13];
        c[3]  = c[4] ^ c[5] ^ c[6] ^ c[11] ^ c[12] ^ c[13];
        c[7]  = c[8] ^ c[9] ^ c[10] ^ c[11] ^ c[12] ^ c[13];
        return c;
    endfunction

    assign new_p       = {bus.dir_cmd, bus.speed_cmd, bus.mode};
    assign refresh_due = REF_EN && has_cmd && (ref_cnt == REF_LAST);
    // A new command takes priority over a refresh expiring in the same cycle.
    assign launch      = (state == IDLE) && (bus.cmd_valid || refresh_due);
    assign launch_p    = bus.cmd_valid ? new_p : payload;

    always_comb begin
        inj_mask = '0;
`ifdef FAULT_INJ_EN
        if (inj_en && (inj_pos <= 4'd13))
            inj_mask[inj_pos] = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            payload  <= '0;
            has_cmd  <= 1'b0;
            ref_cnt  <= '0;
            gap_cnt  <= '0;
            data_r   <= '0;
            avl_r    <= 1'b0;
            tx_cnt_r <= 8'd0;
        end else begin
            avl_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        payload  <= launch_p;
                        has_cmd  <= 1'b1;
                        data_r   <= enc(launch_p) ^ inj_mask;
                        avl_r    <= 1'b1;
                        tx_cnt_r <= tx_cnt_r + 8'd1;
                        ref_cnt  <= '0;
                        gap_cnt  <= '0;
                        state    <= GAP;
                    end else if (REF_EN && has_cmd) begin
                        ref_cnt <= ref_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST)
                        state <= IDLE;
                    else
                        gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.data      = data_r;
    assign bus.avl       = avl_r;
    assign bus.tx_cnt    = tx_cnt_r;

endmodule
